frame_stream_sched: RTL and testbench

FRAME_STREAM_SCHED -- requirements
Module: frame_stream_sched

---
 rtl/frame_sched_pkg.sv | 32 +++
 rtl/frame_sched_csr.sv | 123 ++++++++++++
 rtl/frame_stream_sched.sv | 206 ++++++++++++++++++++
 tb/tb_frame_stream_sched.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// Shared definitions for the frame stream scheduler: FSM state encoding,
// CSR word addresses and the CTRL/STATUS/IRQ bit positions.
package frame_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARM    = 2'd1,
      ST_STREAM = 2'd2
   } sched_state_t;

   localparam logic [3:0] ADDR_CTRL        = 4'd0;
   localparam logic [3:0] ADDR_WIDTH       = 4'd1;
   localparam logic [3:0] ADDR_HEIGHT      = 4'd2;
   localparam logic [3:0] ADDR_STATUS      = 4'd3;
   localparam logic [3:0] ADDR_FRAMES_IN   = 4'd4;
   localparam logic [3:0] ADDR_FRAMES_DONE = 4'd5;
   localparam logic [3:0] ADDR_IRQ         = 4'd6;

   localparam int unsigned CTRL_ENABLE_BIT     = 0;
   localparam int unsigned CTRL_SINGLE_BIT     = 1;
   localparam int unsigned CTRL_SOFT_CLEAR_BIT = 2;

   localparam int unsigned STATUS_STATE_LSB     = 0;
   localparam int unsigned STATUS_INFLIGHT_LSB  = 4;
   localparam int unsigned STATUS_UNDERFLOW_BIT = 8;

   localparam int unsigned IRQ_DONE_BIT = 0;

   // Width of the in-flight frame counter (STATUS bits 7:4).
   localparam int unsigned INFLIGHT_BITS = 4;

endpackage

// File: rtl/frame_sched_csr.sv
// CSR block for the frame stream scheduler.
// Ports:
//   clk, reset_n            clock / async active-low reset
//   avl_*                   Avalon-MM slave; avl_readdata is registered (1-cycle latency)
//   state, inflight,        live status from the scheduler for STATUS readback
//   underflow_err
//   frames_in, frames_done  frame counters for readback
//   res_eof                 sets IRQ.done
//   fsm_clr_enable          scheduler request to drop CTRL.enable (single-shot end)
//   enable, single          CTRL fields
//   width, height           frame geometry (never 0 unless truncation wraps)
//   irq_done                IRQ.done
//   soft_clear              write pulse, combinational from the CTRL write
module frame_sched_csr
   import frame_sched_pkg::*;
#(
   parameter int unsigned DIM_BITS = 12
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [3:0]               avl_address,
   input  logic                     avl_write,
   input  logic [31:0]              avl_writedata,
   input  logic                     avl_read,
   output logic [31:0]              avl_readdata,
   input  sched_state_t             state,
   input  logic [INFLIGHT_BITS-1:0] inflight,
   input  logic                     underflow_err,
   input  logic [31:0]              frames_in,
   input  logic [31:0]              frames_done,
   input  logic                     res_eof,
   input  logic                     fsm_clr_enable,
   output logic                     enable,
   output logic                     single,
   output logic [DIM_BITS-1:0]      width,
   output logic [DIM_BITS-1:0]      height,
   output logic                     irq_done,
   output logic                     soft_clear
);

   logic        wr_ctrl;
   logic        wr_width;
   logic        wr_height;
   logic        wr_irq;
   logic [31:0] rd_mux;

   // max(v,1) first, then truncation to the register width.
   function automatic logic [DIM_BITS-1:0] dim_value(input logic [31:0] v);
      if (v == 32'd0)
         return DIM_BITS'(1);
      else
         return DIM_BITS'(v);
   endfunction

   assign wr_ctrl    = avl_write && (avl_address == ADDR_CTRL);
   assign wr_width   = avl_write && (avl_address == ADDR_WIDTH);
   assign wr_height  = avl_write && (avl_address == ADDR_HEIGHT);
   assign wr_irq     = avl_write && (avl_address == ADDR_IRQ);
   assign soft_clear = wr_ctrl && avl_writedata[CTRL_SOFT_CLEAR_BIT];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable <= 1'b0;
         single <= 1'b0;
         width  <= DIM_BITS'(1);
         height <= DIM_BITS'(1);
      end else begin
         // A software CTRL write takes precedence over the scheduler's
         // single-shot clear in the same cycle.
         if (wr_ctrl) begin
            enable <= avl_writedata[CTRL_ENABLE_BIT] && !avl_writedata[CTRL_SOFT_CLEAR_BIT];
            single <= avl_writedata[CTRL_SINGLE_BIT];
         end else if (fsm_clr_enable) begin
            enable <= 1'b0;
         end
         if (wr_width)
            width <= dim_value(avl_writedata);
         if (wr_height)
            height <= dim_value(avl_writedata);
      end
   end

   // A new result eof wins over a simultaneous write-1-to-clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         irq_done <= 1'b0;
      else if (soft_clear)
         irq_done <= 1'b0;
      else if (res_eof)
         irq_done <= 1'b1;
      else if (wr_irq && avl_writedata[IRQ_DONE_BIT])
         irq_done <= 1'b0;
   end

   always_comb begin
      rd_mux = '0;
      case (avl_address)
         ADDR_CTRL: begin
            rd_mux[CTRL_ENABLE_BIT] = enable;
            rd_mux[CTRL_SINGLE_BIT] = single;
         end
         ADDR_WIDTH:  rd_mux = 32'(width);
         ADDR_HEIGHT: rd_mux = 32'(height);
         ADDR_STATUS: begin
            rd_mux[STATUS_STATE_LSB +: 2]                = state;
            rd_mux[STATUS_INFLIGHT_LSB +: INFLIGHT_BITS] = inflight;
            rd_mux[STATUS_UNDERFLOW_BIT]                 = underflow_err;
         end
         ADDR_FRAMES_IN:   rd_mux = frames_in;
         ADDR_FRAMES_DONE: rd_mux = frames_done;
         ADDR_IRQ:         rd_mux[IRQ_DONE_BIT] = irq_done;
         default:          rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         avl_readdata <= '0;
      else
         avl_readdata <= avl_read ? rd_mux : '0;
   end

endmodule

// File: rtl/frame_stream_sched.sv
// Frame stream scheduler: frames a raw pixel stream into sop/eop/sof/eof
// beats for the conv pipe and limits the number of frames in flight.
// Ports:
//   clk, reset_n        clock / async active-low reset
//   avl_*               CSR slave (see frame_sched_csr)
//   src_valid/src_data  raw pixel input; src_ready only in STREAM
//   dst_*               framed output, one cycle after each accepted beat
//   res_eof             result-stream eof pulse, returns one credit
//   irq                 level, IRQ.done
module frame_stream_sched
   import frame_sched_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned DIM_BITS     = 12,
   parameter int unsigned MAX_INFLIGHT = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [3:0]            avl_address,
   input  logic                  avl_write,
   input  logic [31:0]           avl_writedata,
   input  logic                  avl_read,
   output logic [31:0]           avl_readdata,
   input  logic                  src_valid,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  src_ready,
   output logic                  dst_valid,
   output logic                  dst_sop,
   output logic                  dst_eop,
   output logic                  dst_sof,
   output logic                  dst_eof,
   output logic [DATA_WIDTH-1:0] dst_data,
   input  logic                  res_eof,
   output logic                  irq
);

   sched_state_t             state_q, state_d;
   logic [DIM_BITS-1:0]      col_q, row_q;
   logic [DIM_BITS-1:0]      w_sh, h_sh;
   logic [INFLIGHT_BITS-1:0] inflight_q;
   logic [31:0]              frames_in_q, frames_done_q;
   logic                     underflow_q;

   logic                     enable, single, irq_done, soft_clear;
   logic [DIM_BITS-1:0]      width, height;

   logic                     accept, start_frame, clr_enable;
   logic                     is_sop, is_eop, is_sof, is_eof;
   logic                     credit_take, credit_give;

   frame_sched_csr #(
      .DIM_BITS (DIM_BITS)
   ) u_csr (
      .clk            (clk),
      .reset_n        (reset_n),
      .avl_address    (avl_address),
      .avl_write      (avl_write),
      .avl_writedata  (avl_writedata),
      .avl_read       (avl_read),
      .avl_readdata   (avl_readdata),
      .state          (state_q),
      .inflight       (inflight_q),
      .underflow_err  (underflow_q),
      .frames_in      (frames_in_q),
      .frames_done    (frames_done_q),
      .res_eof        (res_eof),
      .fsm_clr_enable (clr_enable),
      .enable         (enable),
      .single         (single),
      .width          (width),
      .height         (height),
      .irq_done       (irq_done),
      .soft_clear     (soft_clear)
   );

   assign src_ready   = (state_q == ST_STREAM);
   assign accept      = src_valid && src_ready;
   assign is_sop      = (col_q == '0);
   assign is_eop      = (col_q == w_sh - DIM_BITS'(1));
   assign is_sof      = is_sop && (row_q == '0);
   assign is_eof      = is_eop && (row_q == h_sh - DIM_BITS'(1));
   assign credit_take = accept && is_sof;
   assign credit_give = res_eof;
   assign irq         = irq_done;

   // Enable is only sampled at frame boundaries, so a mid-frame disable
   // lets the current frame run to its eof.
   always_comb begin
      state_d     = state_q;
      start_frame = 1'b0;
      clr_enable  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable)
               state_d = ST_ARM;
         end
         ST_ARM: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (inflight_q < INFLIGHT_BITS'(MAX_INFLIGHT)) begin
               state_d     = ST_STREAM;
               start_frame = 1'b1;
            end
         end
         ST_STREAM: begin
            if (accept && is_eof) begin
               if (single) begin
                  clr_enable = 1'b1;
                  state_d    = ST_IDLE;
               end else if (enable) begin
                  state_d = ST_ARM;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         w_sh    <= DIM_BITS'(1);
         h_sh    <= DIM_BITS'(1);
      end else if (soft_clear) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         if (start_frame) begin
            w_sh  <= width;
            h_sh  <= height;
            col_q <= '0;
            row_q <= '0;
         end else if (accept) begin
            if (is_eop) begin
               col_q <= '0;
               row_q <= is_eof ? '0 : row_q + DIM_BITS'(1);
            end else begin
               col_q <= col_q + DIM_BITS'(1);
            end
         end
      end
   end

   // Credit accounting: a frame start and a result return in the same cycle
   // cancel; a return with nothing in flight only flags underflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight_q    <= '0;
         frames_in_q   <= '0;
         frames_done_q <= '0;
         underflow_q   <= 1'b0;
      end else if (soft_clear) begin
         inflight_q    <= '0;
         frames_in_q   <= '0;
         frames_done_q <= '0;
         underflow_q   <= 1'b0;
      end else begin
         case ({credit_take, credit_give})
            2'b10: inflight_q <= inflight_q + INFLIGHT_BITS'(1);
            2'b01: begin
               if (inflight_q == '0)
                  underflow_q <= 1'b1;
               else
                  inflight_q <= inflight_q - INFLIGHT_BITS'(1);
            end
            default: ;
         endcase
         if (credit_take)
            frames_in_q <= frames_in_q + 32'd1;
         if (credit_give)
            frames_done_q <= frames_done_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dst_valid <= 1'b0;
         dst_sop   <= 1'b0;
         dst_eop   <= 1'b0;
         dst_sof   <= 1'b0;
         dst_eof   <= 1'b0;
         dst_data  <= '0;
      end else if (soft_clear) begin
         dst_valid <= 1'b0;
         dst_sop   <= 1'b0;
         dst_eop   <= 1'b0;
         dst_sof   <= 1'b0;
         dst_eof   <= 1'b0;
      end else begin
         dst_valid <= accept;
         dst_sop   <= accept && is_sop;
         dst_eop   <= accept && is_eop;
         dst_sof   <= accept && is_sof;
         dst_eof   <= accept && is_eof;
         if (accept)
            dst_data <= src_data;
      end
   end

endmodule

// File: tb/tb_frame_stream_sched.sv
// Self-checking bench for frame_stream_sched: expected beats are pushed to a
// queue when a beat is accepted and compared against the captured output.
module tb_frame_stream_sched;
   import frame_sched_pkg::*;

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic       sof;
      logic       eof;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [3:0]  avl_address = '0;
   logic        avl_write = 1'b0;
   logic [31:0] avl_writedata = '0;
   logic        avl_read = 1'b0;
   logic [31:0] avl_readdata;
   logic        src_valid = 1'b0;
   logic [7:0]  src_data = '0;
   logic        src_ready;
   logic        dst_valid, dst_sop, dst_eop, dst_sof, dst_eof;
   logic [7:0]  dst_data;
   logic        res_eof = 1'b0;
   logic        irq;

   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t exp_q[$];
   beat_t obs_mem [0:255];
   int    obs_wr = 0;
   int    obs_rd = 0;
   int    m_col, m_row, m_w, m_h, n_acc;

   always #5 clk = ~clk;

   frame_stream_sched #(
      .DATA_WIDTH   (8),
      .DIM_BITS     (12),
      .MAX_INFLIGHT (2)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .avl_address   (avl_address),
      .avl_write     (avl_write),
      .avl_writedata (avl_writedata),
      .avl_read      (avl_read),
      .avl_readdata  (avl_readdata),
      .src_valid     (src_valid),
      .src_data      (src_data),
      .src_ready     (src_ready),
      .dst_valid     (dst_valid),
      .dst_sop       (dst_sop),
      .dst_eop       (dst_eop),
      .dst_sof       (dst_sof),
      .dst_eof       (dst_eof),
      .dst_data      (dst_data),
      .res_eof       (res_eof),
      .irq           (irq)
   );

   // Output capture, sampled on the falling edge.
   always @(negedge clk) begin
      if (dst_valid === 1'b1) begin
         obs_mem[obs_wr % 256] = {dst_data, dst_sop, dst_eop, dst_sof, dst_eof};
         obs_wr = obs_wr + 1;
      end
   end

   // One clock cycle: record an acceptance with its expected framing, then
   // advance past the rising edge and retire single-cycle inputs.
   task automatic tick();
      beat_t e;
      @(negedge clk);
      if (src_valid === 1'b1 && src_ready === 1'b1) begin
         e.data = src_data;
         e.sop  = (m_col == 0);
         e.eop  = (m_col == m_w - 1);
         e.sof  = e.sop && (m_row == 0);
         e.eof  = e.eop && (m_row == m_h - 1);
         exp_q.push_back(e);
         n_acc++;
         if (e.eop) begin
            m_col = 0;
            m_row = e.eof ? 0 : m_row + 1;
         end else begin
            m_col++;
         end
      end
      @(posedge clk);
      #1;
      avl_write = 1'b0;
      avl_read  = 1'b0;
      res_eof   = 1'b0;
      src_data  = 8'($urandom);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
      avl_address   = a;
      avl_writedata = d;
      avl_write     = 1'b1;
      tick();
   endtask

   task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
      avl_address = a;
      avl_read    = 1'b1;
      tick();
      d = avl_readdata;
   endtask

   task automatic model_start(input int w, input int h);
      m_w   = w;
      m_h   = h;
      m_col = 0;
      m_row = 0;
      n_acc = 0;
      exp_q.delete();
      obs_rd = obs_wr;
   endtask

   task automatic run_until_acc(input int target, input int budget, output bit ok);
      int left;
      left = budget;
      while (n_acc < target && left > 0) begin
         tick();
         left--;
      end
      ok = (n_acc >= target);
   endtask

   task automatic soft_clear();
      src_valid = 1'b0;
      csr_write(ADDR_CTRL, 32'h4);
      ticks(2);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      #1 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({dst_valid, dst_sop, dst_eop, dst_sof, dst_eof, src_ready, irq} !== 7'b0 || avl_readdata !== 32'h0 || dst_data !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: dst=%b%b%b%b%b src_ready=%b irq=%b rd=%h data=%h, all required 0",
                  dst_valid, dst_sop, dst_eop, dst_sof, dst_eof, src_ready, irq, avl_readdata, dst_data);
      end
      ticks(2);
      reset_n = 1'b1;
      tick();
      csr_read(ADDR_WIDTH, d);
      n_checks++;
      if (d !== 32'd1) begin n_fail++; $display("FAIL reset_width: got %h required 1", d); end
      csr_read(ADDR_HEIGHT, d);
      n_checks++;
      if (d !== 32'd1) begin n_fail++; $display("FAIL reset_height: got %h required 1", d); end
      csr_read(ADDR_CTRL, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h required 0", d); end
      csr_read(ADDR_STATUS, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h required 0", d); end
   endtask

   task automatic test_basic_frame();
      logic [31:0] d;
      bit          ok;
      beat_t       e, o;
      model_start(4, 2);
      csr_write(ADDR_WIDTH, 32'd4);
      csr_write(ADDR_HEIGHT, 32'd2);
      src_valid = 1'b1;
      csr_write(ADDR_CTRL, 32'h1);
      run_until_acc(8, 40, ok);
      src_valid = 1'b0;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL basic_timeout: accepted %0d required 8", n_acc); end
      ticks(3);
      n_checks++;
      if (obs_wr - obs_rd != 8) begin n_fail++; $display("FAIL basic_count: got %0d beats required 8", obs_wr - obs_rd); end
      while (exp_q.size() > 0 && obs_rd < obs_wr) begin
         e = exp_q.pop_front();
         o = obs_mem[obs_rd % 256];
         obs_rd++;
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL basic_beat: got %h required %h", o, e); end
      end
      csr_read(ADDR_FRAMES_IN, d);
      n_checks++;
      if (d !== 32'd1) begin n_fail++; $display("FAIL basic_frames_in: got %0d required 1", d); end
      soft_clear();
   endtask

   task automatic test_backpressure();
      logic [31:0] d;
      bit          ok;
      beat_t       e, o;
      model_start(4, 2);
      csr_write(ADDR_WIDTH, 32'd4);
      csr_write(ADDR_HEIGHT, 32'd2);
      src_valid = 1'b1;
      csr_write(ADDR_CTRL, 32'h1);
      run_until_acc(16, 80, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL bp_timeout: accepted %0d required 16", n_acc); end
      ticks(5);
      n_checks++;
      if (n_acc != 16 || src_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_stall: accepted %0d src_ready=%b, required 16 and 0", n_acc, src_ready);
      end
      csr_read(ADDR_STATUS, d);
      n_checks++;
      if (d !== 32'h21) begin n_fail++; $display("FAIL bp_status: got %h required 00000021", d); end
      csr_read(ADDR_FRAMES_IN, d);
      n_checks++;
      if (d !== 32'd2) begin n_fail++; $display("FAIL bp_frames_in: got %0d required 2", d); end
      res_eof = 1'b1;
      tick();
      tick();
      n_checks++;
      if (src_ready !== 1'b1) begin n_fail++; $display("FAIL bp_resume: src_ready=%b required 1", src_ready); end
      run_until_acc(24, 40, ok);
      src_valid = 1'b0;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL bp_third_timeout: accepted %0d required 24", n_acc); end
      ticks(3);
      n_checks++;
      if (obs_wr - obs_rd != 24) begin n_fail++; $display("FAIL bp_count: got %0d beats required 24", obs_wr - obs_rd); end
      while (exp_q.size() > 0 && obs_rd < obs_wr) begin
         e = exp_q.pop_front();
         o = obs_mem[obs_rd % 256];
         obs_rd++;
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL bp_beat: got %h required %h", o, e); end
      end
      soft_clear();
   endtask

   task automatic test_single();
      logic [31:0] d;
      bit          ok;
      beat_t       e, o;
      model_start(2, 2);
      csr_write(ADDR_WIDTH, 32'd2);
      csr_write(ADDR_HEIGHT, 32'd2);
      src_valid = 1'b1;
      csr_write(ADDR_CTRL, 32'h3);
      run_until_acc(4, 30, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL single_timeout: accepted %0d required 4", n_acc); end
      ticks(5);
      n_checks++;
      if (n_acc != 4) begin n_fail++; $display("FAIL single_extra: accepted %0d required 4", n_acc); end
      csr_read(ADDR_CTRL, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL single_ctrl: got %h required 00000002", d); end
      csr_read(ADDR_STATUS, d);
      n_checks++;
      if (d[1:0] !== 2'd0) begin n_fail++; $display("FAIL single_state: got %0d required 0", d[1:0]); end
      src_valid = 1'b0;
      ticks(2);
      n_checks++;
      if (obs_wr - obs_rd != 4) begin n_fail++; $display("FAIL single_count: got %0d beats required 4", obs_wr - obs_rd); end
      while (exp_q.size() > 0 && obs_rd < obs_wr) begin
         e = exp_q.pop_front();
         o = obs_mem[obs_rd % 256];
         obs_rd++;
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL single_beat: got %h required %h", o, e); end
      end
      soft_clear();
   endtask

   task automatic test_disable_mid_frame();
      logic [31:0] d;
      bit          ok;
      beat_t       e, o;
      model_start(3, 3);
      csr_write(ADDR_WIDTH, 32'd3);
      csr_write(ADDR_HEIGHT, 32'd3);
      src_valid = 1'b1;
      csr_write(ADDR_CTRL, 32'h1);
      run_until_acc(2, 20, ok);
      csr_write(ADDR_CTRL, 32'h0);
      run_until_acc(9, 30, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL dis_timeout: accepted %0d required 9", n_acc); end
      ticks(5);
      n_checks++;
      if (n_acc != 9) begin n_fail++; $display("FAIL dis_extra: accepted %0d required 9", n_acc); end
      csr_read(ADDR_STATUS, d);
      n_checks++;
      if (d[1:0] !== 2'd0) begin n_fail++; $display("FAIL dis_state: got %0d required 0", d[1:0]); end
      src_valid = 1'b0;
      ticks(2);
      n_checks++;
      if (obs_wr - obs_rd != 9) begin n_fail++; $display("FAIL dis_count: got %0d beats required 9", obs_wr - obs_rd); end
      while (exp_q.size() > 0 && obs_rd < obs_wr) begin
         e = exp_q.pop_front();
         o = obs_mem[obs_rd % 256];
         obs_rd++;
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL dis_beat: got %h required %h", o, e); end
      end
      soft_clear();
   endtask

   task automatic test_underflow_irq();
      logic [31:0] d;
      res_eof = 1'b1;
      tick();
      csr_read(ADDR_STATUS, d);
      n_checks++;
      if (d !== 32'h100) begin n_fail++; $display("FAIL uf_status: got %h required 00000100", d); end
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL uf_irq: got %b required 1", irq); end
      csr_read(ADDR_FRAMES_DONE, d);
      n_checks++;
      if (d !== 32'd1) begin n_fail++; $display("FAIL uf_frames_done: got %0d required 1", d); end
      csr_write(ADDR_IRQ, 32'h1);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c: got %b required 0", irq); end
      res_eof = 1'b1;
      csr_write(ADDR_IRQ, 32'h1);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_race: got %b required 1", irq); end
      csr_read(ADDR_FRAMES_DONE, d);
      n_checks++;
      if (d !== 32'd2) begin n_fail++; $display("FAIL uf_frames_done2: got %0d required 2", d); end
      csr_write(ADDR_WIDTH, 32'd0);
      csr_read(ADDR_WIDTH, d);
      n_checks++;
      if (d !== 32'd1) begin n_fail++; $display("FAIL width_min: got %0d required 1", d); end
      csr_read(4'hA, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h required 0", d); end
      csr_write(ADDR_STATUS, 32'hFFFF_FFFF);
      csr_read(ADDR_STATUS, d);
      n_checks++;
      if (d !== 32'h100) begin n_fail++; $display("FAIL status_ro: got %h required 00000100", d); end
      soft_clear();
      csr_read(ADDR_STATUS, d);
      n_checks++;
      if (d !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL clear_status: got %h irq=%b required 0/0", d, irq); end
      csr_read(ADDR_FRAMES_DONE, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL clear_frames_done: got %0d required 0", d); end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] d;
      bit          ok;
      beat_t       e, o;
      model_start(4, 2);
      csr_write(ADDR_WIDTH, 32'd4);
      csr_write(ADDR_HEIGHT, 32'd2);
      src_valid = 1'b1;
      csr_write(ADDR_CTRL, 32'h1);
      run_until_acc(5, 30, ok);
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (dst_valid !== 1'b0 || dst_eof !== 1'b0 || src_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_out: dst_valid=%b dst_eof=%b src_ready=%b required 0", dst_valid, dst_eof, src_ready);
      end
      n_checks++;
      if (obs_wr - obs_rd != 4) begin n_fail++; $display("FAIL rst_mid_count: got %0d beats required 4", obs_wr - obs_rd); end
      for (int i = 0; i < 4; i++) begin
         if (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front();
            o = obs_mem[obs_rd % 256];
            obs_rd++;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL rst_mid_beat: got %h required %h", o, e); end
         end
      end
      ticks(2);
      reset_n = 1'b1;
      tick();
      csr_read(ADDR_WIDTH, d);
      n_checks++;
      if (d !== 32'd1) begin n_fail++; $display("FAIL rst_mid_width: got %0d required 1", d); end
      model_start(4, 2);
      csr_write(ADDR_WIDTH, 32'd4);
      csr_write(ADDR_HEIGHT, 32'd2);
      csr_write(ADDR_CTRL, 32'h1);
      run_until_acc(8, 40, ok);
      src_valid = 1'b0;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rst_next_timeout: accepted %0d required 8", n_acc); end
      ticks(3);
      n_checks++;
      if (obs_wr - obs_rd != 8) begin n_fail++; $display("FAIL rst_next_count: got %0d beats required 8", obs_wr - obs_rd); end
      while (exp_q.size() > 0 && obs_rd < obs_wr) begin
         e = exp_q.pop_front();
         o = obs_mem[obs_rd % 256];
         obs_rd++;
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL rst_next_beat: got %h required %h", o, e); end
      end
      soft_clear();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m_w = 1; m_h = 1; m_col = 0; m_row = 0; n_acc = 0;
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_single();
      test_disable_mid_frame();
      test_underflow_irq();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
